// File: rtl/nios_irq_aggregator_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : nios_irq_aggregator_if
// Description : Avalon-MM slave bus bundle for the IRQ aggregator register
//               file (3-bit word address, 16-bit data, registered readdata).
// Revision    : 1.0 - initial release
// ============================================================================
interface nios_irq_aggregator_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/nios_irq_aggregator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : nios_irq_aggregator
// Description : Latches, masks and prioritises up to 16 peripheral IRQ
//               sources and drives one registered IRQ line to the Nios II.
//               Optional masked-event counter at address 5, enabled by
//               defining IRQ_AGG_EVENT_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nios_irq_aggregator #(
    parameter int NUM_SRC = 8
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    nios_irq_aggregator_if.slave    avs,
    input  wire logic [NUM_SRC-1:0] irq_in,
    output logic                    irq
);

    localparam logic [2:0] c_addr_pending  = 3'd0;
    localparam logic [2:0] c_addr_mask     = 3'd1;
    localparam logic [2:0] c_addr_edge_sel = 3'd2;
    localparam logic [2:0] c_addr_active   = 3'd3;
    localparam logic [2:0] c_addr_raw      = 3'd4;
    localparam logic [2:0] c_addr_count    = 3'd5;

    logic [NUM_SRC-1:0] r_irq_q;
    logic [NUM_SRC-1:0] r_irq_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_edge_sel;

    logic               w_wr;
    logic [NUM_SRC-1:0] w_wdata;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_pending_next;
    logic [NUM_SRC-1:0] w_enabled;
    logic [3:0]         w_active_idx;
    logic               w_active_valid;
    logic [15:0]        w_count;
    logic [15:0]        w_rdata;
    logic               w_unused_wdata;

    assign w_wr    = avs.chipselect & ~avs.write_n;
    assign w_wdata = avs.writedata[NUM_SRC-1:0];
    // Write-data bits above NUM_SRC carry no state.
    assign w_unused_wdata = ^avs.writedata;

    // Source sampling stage and one-cycle history for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_q    <= '0;
            r_irq_prev <= '0;
        end else begin
            r_irq_q    <= irq_in;
            r_irq_prev <= r_irq_q;
        end
    end

    // Level bits follow the sampled source; edge bits set on a rising edge,
    // clear on W1C, and a coincident set beats the clear.
    always_comb begin
        w_rise         = r_irq_q & ~r_irq_prev;
        w_w1c          = (w_wr && avs.address == c_addr_pending) ? w_wdata : '0;
        w_pending_next = (r_edge_sel & (w_rise | (r_pending & ~w_w1c)))
                       | (~r_edge_sel & r_irq_q);
    end

    // Pending, mask and edge-select register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_mask     <= '0;
            r_edge_sel <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (w_wr && avs.address == c_addr_mask) begin
                r_mask <= w_wdata;
            end
            if (w_wr && avs.address == c_addr_edge_sel) begin
                r_edge_sel <= w_wdata;
            end
        end
    end

    assign w_enabled = r_pending & r_mask;

    // Combined IRQ to the CPU, registered from the enabled pending set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |w_enabled;
        end
    end

    // Priority encode: scan downward so the lowest enabled index wins.
    always_comb begin
        w_active_idx = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_enabled[i]) begin
                w_active_idx = 4'(i);
            end
        end
        w_active_valid = |w_enabled;
    end

`ifdef IRQ_AGG_EVENT_COUNT_EN
    logic [15:0] r_count;
    logic        w_event;
    logic        w_wr_count;

    // One event per cycle in which any masked pending bit newly rises.
    assign w_event    = |(~r_pending & w_pending_next & r_mask);
    assign w_wr_count = w_wr && (avs.address == c_addr_count);

    // Saturating event counter; a write clears it and overrides an event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 16'h0000;
        end else if (w_wr_count) begin
            r_count <= 16'h0000;
        end else if (w_event && r_count != 16'hFFFF) begin
            r_count <= r_count + 16'h0001;
        end
    end

    assign w_count = r_count;
`else
    assign w_count = 16'h0000;
`endif

    // Read multiplexer; unmapped addresses read zero.
    always_comb begin
        w_rdata = 16'h0000;
        case (avs.address)
            c_addr_pending:  w_rdata = 16'(r_pending);
            c_addr_mask:     w_rdata = 16'(r_mask);
            c_addr_edge_sel: w_rdata = 16'(r_edge_sel);
            c_addr_active:   w_rdata = {w_active_valid, 11'd0, w_active_idx};
            c_addr_raw:      w_rdata = 16'(r_irq_q);
            c_addr_count:    w_rdata = w_count;
            default:         w_rdata = 16'h0000;
        endcase
    end

    // Read data sampled every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs.readdata <= 16'h0000;
        end else begin
            avs.readdata <= w_rdata;
        end
    end

endmodule
`default_nettype wire
